// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and TX frame FSM state encoding
package uart_pkg;

  localparam int   DATA_BITS     = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - TX frame FSM, bit timer, bit counter and shift register
// Parity bit after D7 only when UART_TX_PARITY_EN is defined.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] pop_data,
  output logic       pop_req,
  output logic       txd,
  output logic       tx_busy
);

  localparam int              TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          bit_end;
  logic          last_stop;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`else
  // PARITY_ODD has no effect without the parity bit.
  if (PARITY_ODD != 0) begin : g_parity_odd_ignored
  end
`endif

  assign bit_end   = (tmr_q == TMR_LAST);
  assign last_stop = (state_q == ST_STOP) && bit_end && (bit_q == STOP_LAST);
  // Popping on the final stop cycle is what makes consecutive frames gapless.
  assign pop_req   = ((state_q == ST_IDLE) || last_stop) && tx_en && !fifo_empty;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tmr_d   = ((state_q == ST_IDLE) || bit_end) ? '0 : tmr_q + TW'(1);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop_req) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = pop_req ? ST_START : ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop_req) begin
      shreg_d = pop_data;
`ifdef UART_TX_PARITY_EN
      par_d   = (PARITY_ODD != 0) ? ~^pop_data : ^pop_data;
`endif
    end
  end

  always_comb begin
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = UART_IDLE_LVL;
    endcase
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= UART_IDLE_LVL;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;

endmodule

// File: rtl/uart_txfifo_ser.sv
// rtl/uart_txfifo_ser.sv - UART TX byte FIFO feeding the frame serializer onto UART_TXD
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_txfifo_ser
  import uart_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   SCLK,
  input  logic                   RST_n,
  input  logic [7:0]             FIFO_WR_DATA,
  input  logic                   FIFO_WREN,
  input  logic                   TX_EN,
  output logic                   UART_TXD,
  output logic                   TX_BUSY,
  output logic                   FIFO_EMPTY,
  output logic                   FIFO_FULL,
  output logic                   FIFO_OVER,
  output logic [$clog2(DEPTH):0] FIFO_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          over_q, over_d;
  logic          wr_acc;
  logic          pop;

  assign FIFO_FULL  = (count_q == CW'(DEPTH));
  assign FIFO_EMPTY = (count_q == '0);
  // Full is the pre-edge value, so a simultaneous pop never rescues a write.
  assign wr_acc     = FIFO_WREN && !FIFO_FULL;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_acc) - CW'(pop);
    over_d   = FIFO_WREN && FIFO_FULL;
  end

  always_ff @(posedge SCLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      over_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      over_q   <= over_d;
    end
  end

  always_ff @(posedge SCLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= FIFO_WR_DATA;
  end

  uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .STOP_BITS   (STOP_BITS),
    .PARITY_ODD  (PARITY_ODD)
  ) u_shifter (
    .clk       (SCLK),
    .rst_n     (RST_n),
    .tx_en     (TX_EN),
    .fifo_empty(FIFO_EMPTY),
    .pop_data  (mem_q[rd_ptr_q]),
    .pop_req   (pop),
    .txd       (UART_TXD),
    .tx_busy   (TX_BUSY)
  );

  assign FIFO_OVER  = over_q;
  assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_uart_txfifo_ser.sv
// tb/tb_uart_txfifo_ser.sv - self-checking bench for uart_txfifo_ser (follows UART_TX_PARITY_EN)
module tb_uart_txfifo_ser;

  localparam int CPB       = 4;
  localparam int DEPTH     = 32;
  localparam int STOP_BITS = 1;
  localparam int PODD      = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 10 + PAR_BITS + STOP_BITS - 1;
  localparam int FC         = FRAME_BITS * CPB;

  logic       SCLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] FIFO_WR_DATA = 8'h00;
  logic       FIFO_WREN = 1'b0;
  logic       TX_EN = 1'b0;
  logic       UART_TXD, TX_BUSY, FIFO_EMPTY, FIFO_FULL, FIFO_OVER;
  logic [5:0] FIFO_COUNT;

  uart_txfifo_ser #(
    .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS), .PARITY_ODD(PODD)
  ) dut (
    .SCLK(SCLK), .RST_n(RST_n), .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WREN(FIFO_WREN),
    .TX_EN(TX_EN), .UART_TXD(UART_TXD), .TX_BUSY(TX_BUSY), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_FULL(FIFO_FULL), .FIFO_OVER(FIFO_OVER), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 SCLK = ~SCLK;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic [63:0] last_wave;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line bits of one frame, index 0 = start bit; unused high bits read as 1.
  function automatic logic [15:0] frame_bits(input logic [7:0] b);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = (PODD != 0) ? ~^b : ^b;
`endif
    return f;
  endfunction

  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [15:0] f;
    logic [63:0] w;
    f = frame_bits(b);
    w = '0;
    for (int i = 0; i < FC; i++) w[i] = f[i / CPB];
    return w;
  endfunction

  // Receiver: samples each bit mid-period and decodes whole frames.
  bit          m_active = 0;
  logic        m_prev = 1'b1;
  int          m_k = 0;
  int          m_t0 = 0;
  logic [15:0] m_bits = '1;
  initial begin : rx_monitor
    forever begin
      @(negedge SCLK);
      cyc++;
      if (!RST_n) begin
        m_active = 0;
        m_prev   = 1'b1;
      end else if (!m_active) begin
        if (m_prev && !UART_TXD) begin
          m_active = 1;
          m_k      = 0;
          m_t0     = cyc;
          m_bits   = '1;
        end
        m_prev = UART_TXD;
      end else begin
        m_k++;
        if (m_k % CPB == CPB / 2) m_bits[m_k / CPB] = UART_TXD;
        if (m_k == (FRAME_BITS - 1) * CPB + CPB / 2) begin
          m_active = 0;
          rx_q.push_back(m_bits[8:1]);
          rx_t.push_back(m_t0);
          chk("rx_framing", m_bits, frame_bits(m_bits[8:1]));
        end
        m_prev = UART_TXD;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    FIFO_WR_DATA = b;
    FIFO_WREN    = 1'b1;
    @(negedge SCLK);
    FIFO_WREN    = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge SCLK);
      t++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t, quiet;
    t = 0;
    quiet = 0;
    while (quiet < 2 && t < budget) begin
      @(negedge SCLK);
      t++;
      quiet = TX_BUSY ? 0 : quiet + 1;
    end
    chk(tag, quiet >= 2, 1);
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = (rx_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic clear_streams();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  // Single frame from idle with TX_EN=1: pop one edge after the write, TXD one edge after the pop.
  task automatic send_check(input string tag, input logic [7:0] b);
    logic [63:0] w, bz;
    write_byte(b);
    chk({tag, "_count_after_write"}, FIFO_COUNT, 1);
    chk({tag, "_not_empty"}, FIFO_EMPTY, 0);
    @(negedge SCLK);
    chk({tag, "_count_after_pop"}, FIFO_COUNT, 0);
    chk({tag, "_empty_after_pop"}, FIFO_EMPTY, 1);
    chk({tag, "_txd_high_at_pop"}, UART_TXD, 1);
    @(negedge SCLK);
    w  = '0;
    bz = '0;
    for (int i = 0; i < FC; i++) begin
      w[i]  = UART_TXD;
      bz[i] = TX_BUSY;
      @(negedge SCLK);
    end
    last_wave = w;
    chk({tag, "_txd_wave"}, w, exp_wave(b));
    chk({tag, "_busy_wave"}, bz, (64'd1 << FC) - 64'd1);
    chk({tag, "_txd_idle_after"}, UART_TXD, 1);
    chk({tag, "_busy_low_after"}, TX_BUSY, 0);
  endtask

  initial begin : watchdog
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] b, b1, b2;
    int bad, n;
    bit flag;

    // Reset state
    repeat (3) @(negedge SCLK);
    chk("rst_txd", UART_TXD, 1);
    chk("rst_busy", TX_BUSY, 0);
    chk("rst_empty", FIFO_EMPTY, 1);
    chk("rst_full", FIFO_FULL, 0);
    chk("rst_over", FIFO_OVER, 0);
    chk("rst_count", FIFO_COUNT, 0);
    RST_n = 1'b1;
    @(negedge SCLK);

    // 1: single 0xA5 frame, exact waveform
    TX_EN = 1'b1;
    clear_streams();
    send_check("t1", 8'hA5);
    exp_q.push_back(8'hA5);
    wait_rx("t1_rx_count", 1, 4 * CPB);
    cmp_stream("t1_rx_data");

    // 2: fill to full, overflow, then gapless drain
    TX_EN = 1'b0;
    clear_streams();
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("t2_full", FIFO_FULL, 1);
    chk("t2_count32", FIFO_COUNT, 32);
    write_byte(8'hFF);
    chk("t2_over_pulse", FIFO_OVER, 1);
    chk("t2_count_kept", FIFO_COUNT, 32);
    @(negedge SCLK);
    chk("t2_over_one_cycle", FIFO_OVER, 0);
    TX_EN = 1'b1;
    wait_rx("t2_rx_count", 32, 32 * FC + 100);
    cmp_stream("t2_order");
    bad = 0;
    for (int k = 1; k < rx_t.size(); k++)
      if (rx_t[k] - rx_t[0] != k * FC) bad++;
    chk("t2_gapless", bad, 0);
    wait_idle("t2_idle", 2 * FC);
    chk("t2_no_extra_frame", rx_q.size(), 32);
    chk("t2_empty", FIFO_EMPTY, 1);

    // 3: write on a pop edge while full is dropped; non-full write on a pop edge keeps count
    TX_EN = 1'b0;
    clear_streams();
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      write_byte(b);
    end
    chk("t3_full", FIFO_FULL, 1);
    TX_EN = 1'b1;
    write_byte(8'hEE);
    chk("t3_over_on_pop", FIFO_OVER, 1);
    chk("t3_count31", FIFO_COUNT, 31);
    repeat (FC - 1) @(negedge SCLK);
    chk("t3_count_before_pop2", FIFO_COUNT, 31);
    b = 8'($urandom);
    exp_q.push_back(b);
    write_byte(b);
    chk("t3_count_wr_and_pop", FIFO_COUNT, 31);
    chk("t3_not_full", FIFO_FULL, 0);
    wait_rx("t3_rx_count", 33, 33 * FC + 100);
    cmp_stream("t3_stream");
    wait_idle("t3_idle", 2 * FC);

    // 4: TX_EN dropped during D3 lets the frame finish, then holds
    TX_EN = 1'b0;
    clear_streams();
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    write_byte(b1);
    write_byte(b2);
    chk("t4_count2", FIFO_COUNT, 2);
    TX_EN = 1'b1;
    @(negedge SCLK);
    repeat (17) @(negedge SCLK);
    TX_EN = 1'b0;
    wait_idle("t4_first_done", 2 * FC);
    chk("t4_txd_idle", UART_TXD, 1);
    chk("t4_count1", FIFO_COUNT, 1);
    repeat (10) @(negedge SCLK);
    chk("t4_still_count1", FIFO_COUNT, 1);
    chk("t4_still_idle", UART_TXD, 1);
    TX_EN = 1'b1;
    @(negedge SCLK);
    chk("t4_pop_next_edge", FIFO_COUNT, 0);
    @(negedge SCLK);
    chk("t4_start_bit", UART_TXD, 0);
    chk("t4_busy", TX_BUSY, 1);
    wait_rx("t4_rx_count", 2, 2 * FC);
    cmp_stream("t4_stream");
    wait_idle("t4_idle", 2 * FC);

    // 5: asynchronous reset during D5 discards everything
    TX_EN = 1'b0;
    clear_streams();
    b = 8'($urandom);
    b[5] = 1'b0;
    write_byte(b);
    write_byte(8'($urandom));
    TX_EN = 1'b1;
    @(negedge SCLK);
    repeat (25) @(negedge SCLK);
    chk("t5_txd_d5_low", UART_TXD, 0);
    RST_n = 1'b0;
    #1;
    chk("t5_async_txd", UART_TXD, 1);
    chk("t5_async_busy", TX_BUSY, 0);
    @(negedge SCLK);
    @(negedge SCLK);
    RST_n = 1'b1;
    flag = 0;
    repeat (2 * FC) begin
      @(negedge SCLK);
      if (UART_TXD !== 1'b1 || TX_BUSY !== 1'b0) flag = 1;
    end
    chk("t5_nothing_sent", flag, 0);
    chk("t5_count0", FIFO_COUNT, 0);
    chk("t5_empty", FIFO_EMPTY, 1);
    chk("t5_rx_none", rx_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frame for 0x07
    TX_EN = 1'b1;
    send_check("t6", 8'h07);
    chk("t6_parity_bit", last_wave[9 * CPB], (PODD != 0) ? 64'd0 : 64'd1);
`endif

    // Random bursts with TX_EN toggling; stream must match accepted writes
    clear_streams();
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        TX_EN = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) @(negedge SCLK);
        b = 8'($urandom);
        exp_q.push_back(b);
        write_byte(b);
      end
      TX_EN = 1'b1;
      wait_rx("rnd_rx_count", exp_q.size(), (n + 2) * FC);
      wait_idle("rnd_idle", 2 * FC);
      chk("rnd_empty", FIFO_EMPTY, 1);
    end
    cmp_stream("rnd_stream");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
